// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC register with prioritised redirects, stall-deferred redirect and return-address stack
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h00400020,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h80000180,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       StallF,
    input  logic                       ExceptionM,
    input  logic                       JumpD,
    input  logic [WIDTH-1:0]           JumpTargetD,
    input  logic                       BranchTakenD,
    input  logic [WIDTH-1:0]           BranchTargetD,
    input  logic                       CallD,
    input  logic [WIDTH-1:0]           RetAddrD,
    input  logic                       ReturnD,
    input  logic [WIDTH-1:0]           ReturnRegD,
    output logic [WIDTH-1:0]           currPC,
    output logic [WIDTH-1:0]           pcPlus4,
    output logic [$clog2(RAS_DEPTH):0] RasCount,
    output logic                       RasEmpty,
    output logic                       RasFull,
    output logic                       PendingValid,
    output logic                       MisalignedF
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_BR   = 2'd1;
    localparam logic [1:0] PRIO_JMP  = 2'd2;
    localparam logic [1:0] PRIO_RET  = 2'd3;

    logic [WIDTH-1:0] r_pc;
    logic             r_pend_valid;
    logic [1:0]       r_pend_prio;
    logic [WIDTH-1:0] r_pend_tgt;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_ret_tgt;
    logic [1:0]       w_red_prio;
    logic [WIDTH-1:0] w_red_tgt;
    logic             w_ras_nonempty;
    logic [PW-1:0]    w_top_inc;

    assign w_pc_plus4     = r_pc + WIDTH'(4);
    assign w_ras_nonempty = (r_count != '0);
    assign w_top_inc      = r_top + PW'(1);
    assign w_ret_tgt      = w_ras_nonempty ? r_ras[r_top] : ReturnRegD;

    // Exception is handled separately; this picks the best non-exception redirect.
    always_comb begin
        w_red_prio = PRIO_NONE;
        w_red_tgt  = w_pc_plus4;
        if (ReturnD) begin
            w_red_prio = PRIO_RET;
            w_red_tgt  = w_ret_tgt;
        end else if (JumpD) begin
            w_red_prio = PRIO_JMP;
            w_red_tgt  = JumpTargetD;
        end else if (BranchTakenD) begin
            w_red_prio = PRIO_BR;
            w_red_tgt  = BranchTargetD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_prio  <= PRIO_NONE;
            r_pend_tgt   <= '0;
        end else if (ExceptionM) begin
            r_pc         <= EXC_VECTOR;
            r_pend_valid <= 1'b0;
        end else if (StallF) begin
            if (w_red_prio != PRIO_NONE && (!r_pend_valid || w_red_prio >= r_pend_prio)) begin
                r_pend_valid <= 1'b1;
                r_pend_prio  <= w_red_prio;
                r_pend_tgt   <= w_red_tgt;
            end
        end else if (r_pend_valid) begin
            r_pend_valid <= 1'b0;
            r_pc         <= (w_red_prio > r_pend_prio) ? w_red_tgt : r_pend_tgt;
        end else begin
            r_pc <= w_red_tgt;
        end
    end

    // Circular stack: a push when full lands on the oldest slot, which is top+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
        end else if (CallD && ReturnD && w_ras_nonempty) begin
            r_ras[r_top] <= RetAddrD;
        end else if (CallD) begin
            r_top            <= w_top_inc;
            r_ras[w_top_inc] <= RetAddrD;
            if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + CW'(1);
        end else if (ReturnD && w_ras_nonempty) begin
            r_top   <= r_top - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    assign currPC       = r_pc;
    assign pcPlus4      = w_pc_plus4;
    assign RasCount     = r_count;
    assign RasEmpty     = (r_count == '0);
    assign RasFull      = (r_count == CW'(RAS_DEPTH));
    assign PendingValid = r_pend_valid;
    assign MisalignedF  = (r_pc[1:0] != 2'b00);
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h00400020, PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h80000180, exception handler address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port StallF  input  1  hold currPC when high.
REQ-008 SHALL have port ExceptionM  input  1  redirect to EXC_VECTOR.
REQ-009 SHALL have ports JumpD  input  1 and JumpTargetD  input  WIDTH  jump redirect.
REQ-010 SHALL have ports BranchTakenD  input  1 and BranchTargetD  input  WIDTH  taken-branch redirect.
REQ-011 SHALL have ports CallD  input  1 and RetAddrD  input  WIDTH  push return address.
REQ-012 SHALL have ports ReturnD  input  1 and ReturnRegD  input  WIDTH  pop; ReturnRegD is the fallback target.
REQ-013 SHALL have port currPC  output  WIDTH  registered fetch address.
REQ-014 SHALL have port pcPlus4  output  WIDTH  currPC+4, combinational, modulo 2^WIDTH.
REQ-015 SHALL have ports RasCount  output  clog2(RAS_DEPTH)+1, RasEmpty  output  1, and RasFull  output  1.
REQ-016 SHALL have ports PendingValid  output  1  (deferred redirect held) and MisalignedF  output  1  (currPC[1:0]!=0).

Function
REQ-017 Redirect priority SHALL be ExceptionM > ReturnD > JumpD > BranchTakenD > sequential (pcPlus4).
REQ-018 Return target SHALL be the RAS top entry when RasCount>0, else ReturnRegD.
REQ-019 With StallF=0 and PendingValid=0, the next currPC SHALL be the highest-priority redirect target, or pcPlus4 if there is none; latency is 1 cycle.
REQ-020 A redirect (ExceptionM excluded) asserted while StallF=1 SHALL be captured in a pending register with PendingValid=1; currPC SHALL hold.
REQ-021 While the pending register is held, a later higher-or-equal-priority redirect SHALL overwrite it; a lower-priority redirect SHALL be ignored.
REQ-022 On the first cycle with StallF=0 and PendingValid=1, currPC SHALL load the pending target unless a strictly higher-priority redirect is present that cycle, and PendingValid SHALL clear.
REQ-023 ExceptionM SHALL load EXC_VECTOR into currPC on the next edge regardless of StallF, and SHALL clear PendingValid.
REQ-024 CallD SHALL push RetAddrD; each cycle CallD is high SHALL count as exactly one push, independent of StallF.
REQ-025 ReturnD SHALL pop when RasCount>0; a pop on an empty stack SHALL leave the RAS unchanged and use ReturnRegD.
REQ-026 A push while full SHALL overwrite the oldest entry (circular), and RasCount SHALL stay at RAS_DEPTH.
REQ-027 A simultaneous CallD and ReturnD SHALL take the return target from the current top, then replace the top with RetAddrD, leaving RasCount unchanged; on an empty stack this SHALL be a plain push.
REQ-028 RasEmpty SHALL equal (RasCount==0) and RasFull SHALL equal (RasCount==RAS_DEPTH).
REQ-029 MisalignedF SHALL be flagged only; currPC SHALL NOT be modified by it.

Reset
REQ-030 When reset is high at a posedge, currPC SHALL become RESET_PC, RasCount=0, PendingValid=0, and all other inputs SHALL be ignored that cycle.
REQ-031 Reset SHALL take effect mid-stall and mid-redirect, discarding any pending target and all RAS contents.
REQ-032 From the first edge after reset deasserts, currPC SHALL advance normally; no time-based gating is permitted.

Verification
REQ-033 Reset, then 3 unstalled cycles -> currPC = 00400020, 00400024, 00400028, 0040002C.
REQ-034 StallF=1 for 2 cycles with BranchTakenD=1, BranchTargetD=00400100 in the first stalled cycle -> currPC holds and PendingValid=1; on StallF=0, currPC=00400100 next cycle and PendingValid=0.
REQ-035 JumpD and BranchTakenD in the same cycle, then ExceptionM while StallF=1 -> jump target wins; the exception loads 80000180 despite the stall.
REQ-036 RAS_DEPTH=4: push A,B,C,D,E, then 5 returns -> targets E,D,C,B, then ReturnRegD; RasFull is high after the 4th push and RasEmpty is high after the 4th pop.
REQ-037 Simultaneous CallD(X)/ReturnD with top=T -> redirect to T, top becomes X, RasCount unchanged.
REQ-038 Reset asserted mid-stall with PendingValid=1 -> currPC=00400020, PendingValid=0, RasCount=0 on the next edge.
